exposure_timer: RTL and testbench

- Consumer side of the exposure-control interface. It takes the registered 5-bit exposure time (ms) and runs one sensor frame per trigger: erase, expose for the programmed time, then a two-row readout with ADC strobes.
- Clocked by the 1 ms tick, so one cycle equals 1 ms.
- Drives the sensor control pins and reports frame status to the camera top-level FSM.

---
 rtl/exposure_timer.sv | 108 ++++++++++
 tb/tb_exposure_timer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/exposure_timer.sv
// Exposure frame sequencer: erase, expose for a latched (clamped) time,
// then two single-row readouts with an ADC strobe each. One Clk = 1 ms.
module exposure_timer #(
    parameter int EXP_W   = 5,
    parameter int EXP_MIN = 2,
    parameter int EXP_MAX = 30,
    parameter int SETTLE  = 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Init,
    input  logic [EXP_W-1:0] Exp_Time,
    output logic             Erase,
    output logic             Expose,
    output logic             NRE_1,
    output logic             NRE_2,
    output logic             ADC,
    output logic             Busy,
    output logic             Frame_Done,
    output logic [EXP_W-1:0] Remaining
);
    typedef enum logic [1:0] {IDLE, EXPOSE, ROW1, ROW2} state_t;

    localparam int               PH_W    = $clog2(SETTLE + 2);
    localparam logic [PH_W-1:0]  PH_ADC  = PH_W'(SETTLE);
    localparam logic [PH_W-1:0]  PH_LAST = PH_W'(SETTLE + 1);
    localparam logic [EXP_W-1:0] N_MIN   = EXP_W'(EXP_MIN);
    localparam logic [EXP_W-1:0] N_MAX   = EXP_W'(EXP_MAX);

    state_t           state;
    logic [PH_W-1:0]  phase;
    logic [EXP_W-1:0] exp_n;
    logic             adc_next;

    always_comb begin
        exp_n = Exp_Time;
        if (Exp_Time < N_MIN)      exp_n = N_MIN;
        else if (Exp_Time > N_MAX) exp_n = N_MAX;
    end

    // ADC is registered, so it is set on the edge that moves phase onto SETTLE.
    always_comb adc_next = (phase != PH_LAST) && ((phase + PH_W'(1)) == PH_ADC);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            phase      <= '0;
            Erase      <= 1'b1;
            Expose     <= 1'b0;
            NRE_1      <= 1'b1;
            NRE_2      <= 1'b1;
            ADC        <= 1'b0;
            Busy       <= 1'b0;
            Frame_Done <= 1'b0;
            Remaining  <= '0;
        end else begin
            Frame_Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Init) begin
                        state     <= EXPOSE;
                        Erase     <= 1'b0;
                        Expose    <= 1'b1;
                        Busy      <= 1'b1;
                        Remaining <= exp_n;
                    end
                end
                EXPOSE: begin
                    // Remaining doubles as the latched exposure count.
                    if (Remaining == EXP_W'(1)) begin
                        state     <= ROW1;
                        Expose    <= 1'b0;
                        Remaining <= '0;
                        NRE_1     <= 1'b0;
                        phase     <= '0;
                    end else begin
                        Remaining <= Remaining - EXP_W'(1);
                    end
                end
                ROW1: begin
                    ADC <= adc_next;
                    if (phase == PH_LAST) begin
                        state <= ROW2;
                        NRE_1 <= 1'b1;
                        NRE_2 <= 1'b0;
                        phase <= '0;
                    end else begin
                        phase <= phase + PH_W'(1);
                    end
                end
                ROW2: begin
                    ADC <= adc_next;
                    if (phase == PH_LAST) begin
                        state      <= IDLE;
                        NRE_2      <= 1'b1;
                        Erase      <= 1'b1;
                        Busy       <= 1'b0;
                        Frame_Done <= 1'b1;
                        phase      <= '0;
                    end else begin
                        phase <= phase + PH_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_exposure_timer.sv
// Scoreboarded bench for exposure_timer: two instances (SETTLE=1 and 3)
// share stimulus; a frame-offset model predicts every cycle's outputs.
module tb_exposure_timer;
    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       Init = 1'b0;
    logic [4:0] Exp_Time = 5'd0;

    logic       a_erase, a_expose, a_nre1, a_nre2, a_adc, a_busy, a_done;
    logic [4:0] a_rem;
    logic       b_erase, b_expose, b_nre1, b_nre2, b_adc, b_busy, b_done;
    logic [4:0] b_rem;

    exposure_timer dut_a (
        .Clk(Clk), .Reset(Reset), .Init(Init), .Exp_Time(Exp_Time),
        .Erase(a_erase), .Expose(a_expose), .NRE_1(a_nre1), .NRE_2(a_nre2),
        .ADC(a_adc), .Busy(a_busy), .Frame_Done(a_done), .Remaining(a_rem)
    );

    exposure_timer #(.SETTLE(3)) dut_b (
        .Clk(Clk), .Reset(Reset), .Init(Init), .Exp_Time(Exp_Time),
        .Erase(b_erase), .Expose(b_expose), .NRE_1(b_nre1), .NRE_2(b_nre2),
        .ADC(b_adc), .Busy(b_busy), .Frame_Done(b_done), .Remaining(b_rem)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic       erase, expose, nre1, nre2, adc, busy, done;
        logic [4:0] rem;
    } obs_t;

    localparam obs_t IDLE_OBS = 12'b1_0_1_1_0_0_0_00000;

    obs_t got_a, got_b;
    assign got_a = {a_erase, a_expose, a_nre1, a_nre2, a_adc, a_busy, a_done, a_rem};
    assign got_b = {b_erase, b_expose, b_nre1, b_nre2, b_adc, b_busy, b_done, b_rem};

    int n_chk = 0, n_fail = 0;

    // Reference: a frame is just (start, N); outputs are a function of the
    // cycle offset t since the accepting edge.
    int S [2] = '{1, 3};
    bit in_f [2];
    int t [2];
    int n [2];
    obs_t q0[$], q1[$];
    int   fq0[$], fq1[$];
    int   expc [2];
    int   busyc [2];

    function automatic int clamp(logic [4:0] e);
        if (e < 5'd2)  return 2;
        if (e > 5'd30) return 30;
        return int'(e);
    endfunction

    function automatic obs_t expect_out(int d, bit done);
        obs_t o;
        int tt = t[d], nn = n[d], s = S[d];
        o = IDLE_OBS;
        o.done = done;
        if (in_f[d]) begin
            o.erase  = 1'b0;
            o.busy   = 1'b1;
            o.expose = (tt < nn);
            o.rem    = (tt < nn) ? 5'(nn - tt) : 5'd0;
            o.nre1   = !(tt >= nn && tt < nn + s + 2);
            o.nre2   = !(tt >= nn + s + 2);
            o.adc    = (tt == nn + s) || (tt == nn + 2 * s + 2);
        end
        return o;
    endfunction

    initial forever begin
        @(posedge Clk);
        for (int d = 0; d < 2; d++) begin
            bit done;
            obs_t e;
            done = 1'b0;
            if (Reset) begin
                in_f[d] = 1'b0;
                if (d == 0) fq0.delete(); else fq1.delete();
            end else if (in_f[d]) begin
                t[d]++;
                if (t[d] == n[d] + 2 * (S[d] + 2)) begin
                    in_f[d] = 1'b0;
                    done = 1'b1;
                end
            end else if (Init) begin
                in_f[d] = 1'b1;
                t[d] = 0;
                n[d] = clamp(Exp_Time);
                if (d == 0) fq0.push_back(n[d]); else fq1.push_back(n[d]);
            end
            e = expect_out(d, done);
            if (d == 0) q0.push_back(e); else q1.push_back(e);
        end
    end

    task automatic check(input int d, input obs_t g);
        obs_t e;
        int   nf;
        bit   have;
        have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
        n_chk++;
        if (!have) begin
            n_fail++;
            $display("FAIL dut%0d no_expectation t=%0t got=%h", d, $time, g);
            return;
        end
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        if (g !== e) begin
            n_fail++;
            $display("FAIL dut%0d outputs t=%0t got=%b_%05b required=%b_%05b",
                     d, $time, g[11:5], g.rem, e[11:5], e.rem);
        end
        n_chk++;
        if (!g.nre1 && !g.nre2) begin
            n_fail++;
            $display("FAIL dut%0d nre_exclusive t=%0t got both low required at most one", d, $time);
        end
        if (Reset) begin
            expc[d] = 0;
            busyc[d] = 0;
        end else begin
            if (g.expose) expc[d]++;
            if (g.busy)   busyc[d]++;
            if (g.done) begin
                have = (d == 0) ? (fq0.size() > 0) : (fq1.size() > 0);
                n_chk++;
                if (!have) begin
                    n_fail++;
                    $display("FAIL dut%0d frame_unexpected t=%0t", d, $time);
                end else begin
                    nf = (d == 0) ? fq0.pop_front() : fq1.pop_front();
                    if (expc[d] != nf || busyc[d] != nf + 2 * (S[d] + 2)) begin
                        n_fail++;
                        $display("FAIL dut%0d frame_len t=%0t got expose=%0d busy=%0d required expose=%0d busy=%0d",
                                 d, $time, expc[d], busyc[d], nf, nf + 2 * (S[d] + 2));
                    end
                end
                expc[d] = 0;
                busyc[d] = 0;
            end
        end
    endtask

    initial forever begin
        @(posedge Clk);
        #1;
        check(0, got_a);
        check(1, got_b);
    end

    task automatic check_reset_now(input string nm);
        n_chk += 2;
        if (got_a !== IDLE_OBS) begin
            n_fail++;
            $display("FAIL %s dut0 got=%h required=%h", nm, got_a, IDLE_OBS);
        end
        if (got_b !== IDLE_OBS) begin
            n_fail++;
            $display("FAIL %s dut1 got=%h required=%h", nm, got_b, IDLE_OBS);
        end
    endtask

    task automatic cyc(input int k);
        repeat (k) @(negedge Clk);
    endtask

    task automatic pulse(input logic [4:0] e);
        @(negedge Clk);
        Exp_Time = e;
        Init = 1'b1;
        @(negedge Clk);
        Init = 1'b0;
    endtask

    // Assert Reset between edges and check outputs before the next edge.
    task automatic async_reset(input string nm);
        @(negedge Clk);
        #2 Reset = 1'b1;
        #1 check_reset_now(nm);
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    initial begin
        logic [4:0] clamp_tab [4];
        clamp_tab = '{5'd0, 5'd31, 5'd2, 5'd30};
        #1 Reset = 1'b1;
        #1 check_reset_now("reset_state");
        cyc(2);
        Reset = 1'b0;

        pulse(5'd15);
        cyc(30);

        foreach (clamp_tab[i]) begin
            pulse(clamp_tab[i]);
            cyc(42);
        end

        // Exp_Time change and a second Init mid-frame must both be ignored.
        pulse(5'd10);
        cyc(2);
        Exp_Time = 5'd25;
        cyc(2);
        Init = 1'b1;
        @(negedge Clk);
        Init = 1'b0;
        cyc(25);

        Exp_Time = 5'd5;
        Init = 1'b1;
        cyc(40);
        Init = 1'b0;
        cyc(20);

        pulse(5'd20);
        cyc(5);
        async_reset("reset_mid_expose");
        cyc(2);
        pulse(5'd15);
        cyc(30);

        pulse(5'd2);
        cyc(4);
        async_reset("reset_mid_row2");
        cyc(2);
        pulse(5'd4);
        cyc(20);

        repeat (400) begin
            @(negedge Clk);
            Init = ($urandom_range(3) == 0);
            Exp_Time = 5'($urandom);
            Reset = ($urandom_range(150) == 0);
        end
        @(negedge Clk);
        Init = 1'b0;
        Reset = 1'b0;
        cyc(50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
